// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB load/store master:
//   - RV32I load/store funct3 encodings
//   - master FSM state type
//   - APB address map (slave i lives at APB_BASE + i*SLV_STRIDE)
// -----------------------------------------------------------------------------
package apb_pkg;

    // Load encodings
    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam logic [31:0] APB_BASE   = 32'h1000_0000;
    localparam logic [31:0] SLV_STRIDE = 32'h0000_1000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

endpackage

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational byte-lane steering for the load/store master.
//   we_i       1 = store, 0 = load
//   funct3_i   RV32I load/store funct3
//   off_i      byte offset within the word (addr[1:0])
//   wdata_i    right-aligned store data
//   rdata_i    raw 32-bit word returned by the selected slave
//   pwdata_o   lane-replicated store data
//   pstrb_o    byte strobes (0 for loads)
//   rdata_o    extracted and sign/zero-extended load data
//   misalign_o misaligned offset or unused funct3
// -----------------------------------------------------------------------------
module lsu_align
    import apb_pkg::*;
(
    input  logic        we_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] pwdata_o,
    output logic [3:0]  pstrb_o,
    output logic [31:0] rdata_o,
    output logic        misalign_o
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    // Shift the addressed byte / half down to bit 0.
    assign byte_v = 8'(rdata_i >> {off_i, 3'b000});
    assign half_v = 16'(rdata_i >> {off_i[1], 4'b0000});

    always_comb begin
        pwdata_o   = '0;
        pstrb_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        if (we_i) begin
            case (funct3_i)
                SB: begin
                    pwdata_o = {4{wdata_i[7:0]}};
                    pstrb_o  = 4'b0001 << off_i;
                end
                SH: begin
                    pwdata_o   = {2{wdata_i[15:0]}};
                    pstrb_o    = 4'b0011 << off_i;
                    misalign_o = off_i[0];
                end
                SW: begin
                    pwdata_o   = wdata_i;
                    pstrb_o    = 4'b1111;
                    misalign_o = |off_i;
                end
                default: misalign_o = 1'b1;
            endcase
        end else begin
            case (funct3_i)
                LB:  rdata_o = {{24{byte_v[7]}}, byte_v};
                LBU: rdata_o = {24'h0, byte_v};
                LH: begin
                    rdata_o    = {{16{half_v[15]}}, half_v};
                    misalign_o = off_i[0];
                end
                LHU: begin
                    rdata_o    = {16'h0, half_v};
                    misalign_o = off_i[0];
                end
                LW: begin
                    rdata_o    = rdata_i;
                    misalign_o = |off_i;
                end
                default: misalign_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/apb_lsu_master.sv
// -----------------------------------------------------------------------------
// apb_lsu_master
// Single-outstanding load/store master from the RV32I datapath to APB3+PSTRB.
//   clk, reset             clock, asynchronous active-high reset
//   req_*                  CPU request (held stable until resp_ready)
//   resp_ready/err/rdata   one-cycle completion pulse with status and load data
//   PADDR..PSTRB           APB master outputs, PSEL one-hot over NUM_SLV slaves
//   PRDATA, PREADY         per-slave read data / ready, slave i at slice i
//   dbg_state              current FSM state (apb_state_e encoding)
// Handshake: a request is accepted only in IDLE while req_valid=1; it completes
// with exactly one resp_ready pulse, after which the master returns to IDLE and
// may accept the next request one cycle later.
// -----------------------------------------------------------------------------
module apb_lsu_master
    import apb_pkg::*;
#(
    parameter int NUM_SLV = 4,   // up to 16: the slave index is addr[15:12]
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    input  logic                   req_we,
    input  logic [2:0]             req_funct3,
    input  logic [31:0]            req_addr,
    input  logic [31:0]            req_wdata,
    output logic                   resp_ready,
    output logic                   resp_err,
    output logic [31:0]            resp_rdata,
    output logic [31:0]            PADDR,
    output logic                   PWRITE,
    output logic                   PENABLE,
    output logic [NUM_SLV-1:0]     PSEL,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    input  logic [NUM_SLV*32-1:0]  PRDATA,
    input  logic [NUM_SLV-1:0]     PREADY,
    output logic [1:0]             dbg_state
);

    localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [31:0] DEC_SPAN = 32'(NUM_SLV) * SLV_STRIDE;

    apb_state_e      state_q, state_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [31:0]     addr_q;
    logic [31:0]     pwdata_q;
    logic [3:0]      pstrb_q;
    logic [3:0]      sel_q;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            accept;

    logic [31:0]     slv_off;
    logic            dec_err;
    logic            a_we;
    logic [2:0]      a_f3;
    logic [1:0]      a_off;
    logic [31:0]     a_pwdata, a_rdata;
    logic [3:0]      a_pstrb;
    logic            a_mis;
    logic            pready_sel;
    logic [31:0]     prdata_sel;

    // Unsigned wrap makes addresses below APB_BASE land far outside the span.
    assign slv_off = req_addr - APB_BASE;
    assign dec_err = (slv_off >= DEC_SPAN);

    // In IDLE the aligner checks the incoming request; afterwards it formats
    // the returned word using the latched request.
    assign a_we  = (state_q == IDLE) ? req_we         : we_q;
    assign a_f3  = (state_q == IDLE) ? req_funct3     : f3_q;
    assign a_off = (state_q == IDLE) ? req_addr[1:0]  : addr_q[1:0];

    lsu_align u_align (
        .we_i       (a_we),
        .funct3_i   (a_f3),
        .off_i      (a_off),
        .wdata_i    (req_wdata),
        .rdata_i    (prdata_sel),
        .pwdata_o   (a_pwdata),
        .pstrb_o    (a_pstrb),
        .rdata_o    (a_rdata),
        .misalign_o (a_mis)
    );

    // Selected-slave return path and one-hot select; PREADY of other slaves
    // never reaches the FSM.
    always_comb begin
        pready_sel = 1'b0;
        prdata_sel = '0;
        PSEL       = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_q == 4'(i)) begin
                pready_sel = PREADY[i];
                prdata_sel = PRDATA[32*i +: 32];
                PSEL[i]    = (state_q == SETUP) || (state_q == ACCESS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (dec_err || a_mis) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = RESP;
                    end else begin
                        accept  = 1'b1;
                        err_d   = 1'b0;
                        state_d = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = ACCESS;
            end
            ACCESS: begin
                if (pready_sel) begin
                    err_d = 1'b0;
                    if (!we_q) rdata_d = a_rdata;
                    state_d = RESP;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= '0;
            addr_q   <= '0;
            pwdata_q <= '0;
            pstrb_q  <= '0;
            sel_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                we_q     <= req_we;
                f3_q     <= req_funct3;
                addr_q   <= req_addr;
                pwdata_q <= a_pwdata;
                pstrb_q  <= a_pstrb;
                sel_q    <= slv_off[15:12];
            end
        end
    end

    assign resp_ready = (state_q == RESP);
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = rdata_q;
    assign PADDR      = {addr_q[31:2], 2'b00};
    assign PWRITE     = we_q;
    assign PENABLE    = (state_q == ACCESS);
    assign PWDATA     = pwdata_q;
    assign PSTRB      = pstrb_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_apb_lsu_master.sv
// -----------------------------------------------------------------------------
// tb_apb_lsu_master
// Directed and randomized transactions against apb_lsu_master, checked by a
// transaction-level reference model (byte sizes, masks, address ranges).
// -----------------------------------------------------------------------------
module tb_apb_lsu_master;
    import apb_pkg::*;

    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_ready;
    logic                  resp_err;
    logic [31:0]           resp_rdata;
    logic [31:0]           PADDR;
    logic                  PWRITE;
    logic                  PENABLE;
    logic [NUM_SLV-1:0]    PSEL;
    logic [31:0]           PWDATA;
    logic [3:0]            PSTRB;
    logic [NUM_SLV*32-1:0] PRDATA;
    logic [NUM_SLV-1:0]    PREADY;
    logic [1:0]            dbg_state;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_rdata;

    apb_lsu_master #(.NUM_SLV(NUM_SLV), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_ready (resp_ready),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PSEL       (PSEL),
        .PWDATA     (PWDATA),
        .PSTRB      (PSTRB),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Transaction view: access size in bytes, legal address window, lane
    // replication by modulo, load extraction by shift/mask.
    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] word,
                                  output logic err, output int sel, output logic [31:0] pwd,
                                  output logic [3:0] strb, output logic [31:0] fmt);
        bit   legal, dec;
        int   size, off;
        logic [63:0] mask, v;
        legal = we ? (f3 == SB || f3 == SH || f3 == SW)
                   : (f3 == LB || f3 == LH || f3 == LW || f3 == LBU || f3 == LHU);
        size  = 1 << f3[1:0];
        off   = int'(addr[1:0]);
        dec   = (addr >= APB_BASE) && (addr < APB_BASE + NUM_SLV * SLV_STRIDE);
        err   = !legal || !dec || ((off % size) != 0);
        sel   = dec ? int'((addr - APB_BASE) / SLV_STRIDE) : 0;
        pwd   = '0;
        strb  = '0;
        fmt   = '0;
        if (legal && we) begin
            strb = 4'(((1 << size) - 1) << off);
            for (int i = 0; i < 4; i++) pwd[8*i +: 8] = wdata[8*(i % size) +: 8];
        end
        if (legal && !we) begin
            mask = (64'd1 << (8 * size)) - 64'd1;
            v    = {32'h0, word >> (8 * off)} & mask;
            if (!f3[2] && size < 4 && v[8*size-1]) v = v | ~mask;
            fmt = v[31:0];
        end
    endfunction

    // ---------------- driver: one full request/response ----------------
    // waits < 0 means the selected slave never raises PREADY.
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] word,
                           input int waits, input bit hold);
        logic e_err, fin_err;
        int e_sel, e_lat, e_pen, cyc, pen;
        logic [31:0] e_pwd, e_fmt;
        logic [3:0] e_strb;
        logic [NUM_SLV-1:0] e_psel, r;
        bit done;
        model(we, f3, addr, wdata, word, e_err, e_sel, e_pwd, e_strb, e_fmt);
        e_psel = '0;
        if (!e_err) e_psel[e_sel] = 1'b1;
        if (e_err) begin
            e_lat = 1; e_pen = 0;
        end else if (waits < 0) begin
            e_lat = 2 + TIMEOUT; e_pen = TIMEOUT;
        end else begin
            e_lat = 3 + waits; e_pen = waits + 1;
        end
        fin_err = e_err || (waits < 0);
        if (fin_err) exp_rdata = '0;
        else if (!we) exp_rdata = e_fmt;

        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        for (int s = 0; s < NUM_SLV; s++)
            PRDATA[32*s +: 32] = (!e_err && s == e_sel) ? word : $urandom;
        r = NUM_SLV'($urandom);
        if (!e_err) r[e_sel] = 1'b0;
        PREADY = r;

        cyc = 0; pen = 0; done = 0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (resp_ready) begin
                done = 1;
            end else begin
                chk("apb_ctrl", {PSEL, PENABLE}, {e_psel, cyc >= 2});
                if (!e_err)
                    chk("apb_fields", {PADDR, PWRITE, PWDATA, PSTRB},
                        {addr[31:2], 2'b00, we, e_pwd, e_strb});
                r = NUM_SLV'($urandom);
                if (!e_err) r[e_sel] = PENABLE && (pen == waits);
                if (PENABLE) pen++;
                PREADY = r;
            end
        end
        chk("latency", cyc, e_lat);
        chk("penable_cycles", pen, e_pen);
        chk("resp_err", resp_err, fin_err);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_bus_idle", {PSEL, PENABLE}, '0);

        if (hold) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_reaccept_held", {resp_ready, dbg_state}, {1'b0, IDLE});
            req_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("no_reaccept_after", {resp_ready, dbg_state}, {1'b0, IDLE});
        end else begin
            req_valid = 1'b0;
        end
        PREADY = '0;
    endtask

    // ---------------- stimulus ----------------
    logic [2:0] ld_ops [5] = '{LB, LH, LW, LBU, LHU};
    logic [2:0] st_ops [3] = '{SB, SH, SW};

    initial begin
        int n, slv, waits, size;
        logic we;
        logic [2:0] f3;
        logic [31:0] addr;

        reset = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = '0;
        exp_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {resp_ready, resp_err, resp_rdata, PADDR, PWRITE, PENABLE, PSEL, PWDATA, PSTRB, dbg_state},
            {1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, {NUM_SLV{1'b0}}, 32'h0, 4'h0, IDLE});
        reset = 1'b0;

        // SW to slave 0, zero wait states
        run_txn(1'b1, SW, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
        // SB to slave 1, top byte lane
        run_txn(1'b1, SB, 32'h1000_1003, 32'h0000_00A5, 32'h0, 0, 1'b0);
        chk("sb_lanes", {PWDATA, PSTRB, PSEL}, {32'hA5A5_A5A5, 4'b1000, {NUM_SLV{1'b0}}});
        run_txn(1'b0, LB, 32'h1000_1003, 32'h0, 32'hA512_3456, 0, 1'b0);
        chk("lb_literal", resp_rdata, 32'hFFFF_FFA5);
        run_txn(1'b0, LBU, 32'h1000_1003, 32'h0, 32'hA512_3456, 1, 1'b0);
        chk("lbu_literal", resp_rdata, 32'h0000_00A5);
        run_txn(1'b0, LH, 32'h1000_0002, 32'h0, 32'h8001_1234, 0, 1'b0);
        chk("lh_literal", resp_rdata, 32'hFFFF_8001);
        run_txn(1'b0, LHU, 32'h1000_0002, 32'h0, 32'h8001_1234, 0, 1'b0);
        chk("lhu_literal", resp_rdata, 32'h0000_8001);
        // misaligned half
        run_txn(1'b0, LH, 32'h1000_0001, 32'h0, 32'h8001_1234, 0, 1'b0);
        // slave 2 with 3 wait states
        run_txn(1'b1, SW, 32'h1000_2008, 32'h1234_5678, 32'h0, 3, 1'b0);
        // slave never ready -> timeout
        run_txn(1'b0, LW, 32'h1000_1010, 32'h0, 32'hCAFE_F00D, -1, 1'b0);
        // decode errors, one with req_valid held through RESP
        run_txn(1'b0, LW, 32'h2000_0000, 32'h0, 32'h0, 0, 1'b1);
        run_txn(1'b0, LW, 32'h1000_4000, 32'h0, 32'h0, 0, 1'b0);
        // unused funct3
        run_txn(1'b0, 3'b011, 32'h1000_0000, 32'h0, 32'h0, 0, 1'b0);
        // store store data stays after a load (rdata holds)
        run_txn(1'b0, LW, 32'h1000_3000, 32'h0, 32'h0BAD_CAFE, 2, 1'b0);
        run_txn(1'b1, SH, 32'h1000_3002, 32'h0000_BEEF, 32'h0, 0, 1'b1);

        // reset asserted during ACCESS aborts the transfer
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = LW; req_addr = 32'h1000_3000;
        PREADY = '0;
        n = 0;
        while (!PENABLE && n < 10) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        chk("reached_access", PENABLE, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("reset_abort_bus", {PSEL, PENABLE}, '0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk("reset_no_resp", resp_ready, 1'b0);
        end
        req_valid = 1'b0;
        reset = 1'b0;
        exp_rdata = '0;
        run_txn(1'b0, LW, 32'h1000_3004, 32'h0, 32'h1357_9BDF, 1, 1'b0);

        // randomized traffic
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1));
            f3 = we ? st_ops[$urandom_range(0, 2)] : ld_ops[$urandom_range(0, 4)];
            if ($urandom_range(0, 9) == 0) f3 = 3'b011;
            slv = $urandom_range(0, NUM_SLV);
            addr = APB_BASE + 32'(slv) * SLV_STRIDE + 32'($urandom_range(0, 4095));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            size = 1 << f3[1:0];
            if ($urandom_range(0, 2) != 0) addr = addr & ~(32'(size) - 32'd1);
            waits = $urandom_range(0, 3);
            if ($urandom_range(0, 14) == 0) waits = -1;
            run_txn(we, f3, addr, $urandom, $urandom, waits, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apb_lsu_master.md
Name: apb_lsu_master

Overview:
- Load/store bus master between the multi-cycle RV32I datapath and the APB interconnect. It takes one CPU load or store request at a time and decodes the target slave. It converts the request into an APB3+PSTRB transfer.
- Stores are sent as byte-lane writes using PSTRB. Loads are extracted and sign- or zero-extended inside this block.
- Replaces direct CPU-to-RAM wiring. The RAM slave then only sees word addresses plus strobes.

Parameters:
- NUM_SLV, 4, number of APB slaves; slave i decoded at 0x1000_0000 + i*0x1000.
- TIMEOUT, 16, maximum ACCESS cycles waiting for PREADY before a bus error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- req_valid  in  1  CPU request; held high with stable fields until resp_ready.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I load/store funct3.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_ready  out  1  one-cycle completion pulse.
- resp_err  out  1  valid with resp_ready: misaligned, decode or timeout error.
- resp_rdata  out  32  formatted load data; valid with resp_ready.
- PADDR  out  32  word-aligned address {addr[31:2],2'b00}.
- PWRITE  out  1  APB write.
- PENABLE  out  1  APB enable.
- PSEL  out  NUM_SLV  one-hot select.
- PWDATA  out  32  lane-replicated store data.
- PSTRB  out  4  byte strobes; 0 for reads.
- PRDATA  in  NUM_SLV*32  slave read data, slave i at [32i+31:32i].
- PREADY  in  NUM_SLV  slave ready.

Behaviour:
- Reset: all outputs 0, state IDLE. Reset asserted mid-transfer aborts immediately: PSEL and PENABLE drop asynchronously and no response is issued.
- FSM states are IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - On req_valid, latch we, funct3, addr and wdata.
  - Decode the target: addr[31:16] must equal 16'h1000 and addr[15:12] must be < NUM_SLV. Otherwise it is a decode error.
  - Alignment: SH/LH/LHU require addr[0]=0; SW/LW require addr[1:0]=0. Otherwise it is a misaligned error.
  - Any error goes straight to RESP with err=1 and no APB activity. Otherwise go to SETUP.
- SETUP:
  - PSEL[sel]=1, PENABLE=0.
  - PADDR, PWRITE, PWDATA and PSTRB are valid and stay stable through ACCESS.
  - Next state is ACCESS.
- ACCESS:
  - PSEL[sel]=1, PENABLE=1. A timeout counter starts at 0 and increments each cycle.
  - PREADY[sel]=1: register formatted data into resp_rdata (loads only), err=0, go to RESP.
  - Counter reaching TIMEOUT-1 without PREADY: err=1, go to RESP.
  - PREADY on unselected slaves is ignored.
- RESP: resp_ready=1 for exactly one cycle, then IDLE. A req_valid still high during RESP is not re-accepted. Acceptance resumes from IDLE the following cycle.
- Minimum latency from req_valid in IDLE to resp_ready: valid access = 4 cycles with zero wait states; error = 2 cycles.
- Store lanes, with o = addr[1:0]:
  - SB: PWDATA={4{wdata[7:0]}}, PSTRB=4'b0001<<o.
  - SH: PWDATA={2{wdata[15:0]}}, PSTRB=4'b0011<<o.
  - SW: PWDATA=wdata, PSTRB=4'b1111.
- Load format from PRDATA slice w:
  - LB/LBU select byte w[8o+7:8o], sign- or zero-extended.
  - LH/LHU select half w[16*addr[1]+15:...], sign- or zero-extended.
  - LW passes the word unchanged.
- Unused funct3 (011, 110, 111): treated as misaligned/illegal, err=1.
- resp_rdata holds its last value outside RESP. It is 0 after an error.

Decomposition:
- Shared package apb_pkg: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), state typedef (IDLE, SETUP, ACCESS, RESP), APB_BASE = 32'h1000_0000, SLV_STRIDE = 32'h1000.
- One sub-module, lsu_align:
  - Purely combinational.
  - Produces PWDATA and PSTRB for stores and formatted rdata for loads, from funct3 and offset.
  - Produces the misaligned flag.

Test Plan:
- SW addr 0x1000_0004, wdata 0xDEADBEEF, slave 0 PREADY=1 immediately -> SETUP then ACCESS with PSEL=0001, PADDR=0x1000_0004, PSTRB=1111; resp_ready 4 cycles after req_valid, err=0.
- SB addr 0x1000_1003, wdata 0x000000A5 -> PSEL=0010, PWDATA=0xA5A5A5A5, PSTRB=1000; then LB same addr with PRDATA=0xA5xxxxxx -> resp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
- LH addr 0x1000_0002 with PRDATA=0x8001_1234 -> rdata=0xFFFF8001; LHU -> 0x00008001; LH addr 0x1000_0001 -> err=1 after 2 cycles, PSEL never asserted.
- Slave 2 holds PREADY low 3 cycles -> PENABLE held 4 cycles, PADDR stable throughout; PREADY=0 forever -> err=1 after TIMEOUT ACCESS cycles.
- LW addr 0x2000_0000 or slave index >= NUM_SLV -> decode err=1, no APB activity; req_valid held through RESP -> exactly one response.
- Reset asserted during ACCESS -> PSEL/PENABLE 0 same cycle, no resp_ready; a new request after reset completes normally.
